// File: rtl/dfe_slicer_scheduler_pkg.sv
// Shared types, constants and the slicer-level decoder for the DFE slicer scheduler.
package dfe_sched_pkg;

    localparam int SIGNAL_RESOLUTION     = 8;
    localparam int PULSE_RESPONSE_LENGTH = 2;
    localparam int W                     = SIGNAL_RESOLUTION * PULSE_RESPONSE_LENGTH;
    localparam int SYMBOL_SEPERATION     = 56;
    localparam int NUM_TAPS              = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPUTE = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    typedef logic [1:0]        pam4_sym_t;
    typedef logic signed [2:0] hist_t;

    localparam pam4_sym_t SYM_M3 = 2'b00;
    localparam pam4_sym_t SYM_M1 = 2'b01;
    localparam pam4_sym_t SYM_P1 = 2'b10;
    localparam pam4_sym_t SYM_P3 = 2'b11;

    localparam logic signed [W-1:0] LVL_P1 = W'(SYMBOL_SEPERATION / 2);
    localparam logic signed [W-1:0] LVL_P3 = W'((3 * SYMBOL_SEPERATION) / 2);

    typedef struct packed {
        logic      match;
        pam4_sym_t sym;
        hist_t     mult;
    } decision_t;

    // Unmatched levels report match=0 and fall back to the +1 decision.
    function automatic decision_t feedback_to_sym(input logic signed [W-1:0] level);
        decision_t d;
        d.match = 1'b1;
        if (level == LVL_P1) begin
            d.sym  = SYM_P1;
            d.mult = 3'sd1;
        end else if (level == -LVL_P1) begin
            d.sym  = SYM_M1;
            d.mult = -3'sd1;
        end else if (level == LVL_P3) begin
            d.sym  = SYM_P3;
            d.mult = 3'sd3;
        end else if (level == -LVL_P3) begin
            d.sym  = SYM_M3;
            d.mult = -3'sd3;
        end else begin
            d.match = 1'b0;
            d.sym   = SYM_P1;
            d.mult  = 3'sd1;
        end
        return d;
    endfunction

endpackage

// File: rtl/dfe_slicer_scheduler_isi_calc.sv
// Combinational post-cursor ISI multiply-accumulate with saturating subtraction from the sample.
module dfe_isi_calc
    import dfe_sched_pkg::*;
(
    input  logic signed [W-1:0]          i_sample,
    input  logic [NUM_TAPS*SIGNAL_RESOLUTION-1:0] i_coef,
    input  logic [NUM_TAPS*3-1:0]        i_hist,
    output logic signed [W-1:0]          o_estimation
);

    localparam logic signed [W+1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

    function automatic logic signed [W+1:0] sat_w(input logic signed [W+1:0] v);
        if (v > MAX_V) begin
            return MAX_V;
        end else if (v < MIN_V) begin
            return MIN_V;
        end else begin
            return v;
        end
    endfunction

    logic signed [SIGNAL_RESOLUTION+2:0] w_coef_x;
    logic signed [SIGNAL_RESOLUTION+2:0] w_hist_x;
    logic signed [SIGNAL_RESOLUTION+2:0] w_prod;
    logic signed [W+1:0]                 w_isi_sum;
    logic signed [W+1:0]                 w_isi_sat;
    logic signed [W+1:0]                 w_est_raw;
    logic signed [W+1:0]                 w_est_sat;

    // Tap MAC, then clamp the ISI and the difference to the signed datapath range.
    always_comb begin
        w_coef_x  = '0;
        w_hist_x  = '0;
        w_prod    = '0;
        w_isi_sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_coef_x  = (SIGNAL_RESOLUTION+3)'($signed(i_coef[k*SIGNAL_RESOLUTION +: SIGNAL_RESOLUTION]));
            w_hist_x  = (SIGNAL_RESOLUTION+3)'($signed(i_hist[k*3 +: 3]));
            w_prod    = w_coef_x * w_hist_x;
            w_isi_sum = w_isi_sum + (W+2)'(w_prod);
        end
        w_isi_sat    = sat_w(w_isi_sum);
        w_est_raw    = (W+2)'(i_sample) - w_isi_sat;
        w_est_sat    = sat_w(w_est_raw);
        o_estimation = w_est_sat[W-1:0];
    end

endmodule

// File: rtl/dfe_slicer_scheduler.sv
// PAM4 DFE slicer sequencer: sample -> ISI-corrected estimate -> slicer -> symbol out.
// Optional DFE_SCHED_STATS_EN adds sym_count/tie_count statistics ports.
module dfe_slicer_scheduler
    import dfe_sched_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic signed [W-1:0]                   s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [NUM_TAPS*SIGNAL_RESOLUTION-1:0] tap_coef,
    output logic signed [W-1:0]                   slc_estimation,
    output logic                                  slc_e_valid,
    input  logic signed [W-1:0]                   slc_feedback,
    input  logic                                  slc_f_valid,
    output logic [1:0]                            m_symbol,
    output logic signed [W-1:0]                   m_level,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic                                  tie_err
`ifdef DFE_SCHED_STATS_EN
    ,
    output logic [31:0]                           sym_count,
    output logic [15:0]                           tie_count
`endif
);

    state_t               r_state;
    logic signed [W-1:0]  r_sample;
    logic [NUM_TAPS*3-1:0] r_hist;
    hist_t                r_dec_mult;
    logic signed [W-1:0]  w_est;
    decision_t            w_dec;

    dfe_isi_calc u_isi_calc (
        .i_sample     (r_sample),
        .i_coef       (tap_coef),
        .i_hist       (r_hist),
        .o_estimation (w_est)
    );

    assign w_dec = feedback_to_sym(slc_feedback);

    // Sequencing FSM; every output is a register updated only here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_sample       <= '0;
            r_hist         <= '0;
            r_dec_mult     <= 3'sd0;
            s_ready        <= 1'b0;
            slc_estimation <= '0;
            slc_e_valid    <= 1'b0;
            m_symbol       <= SYM_M3;
            m_level        <= '0;
            m_valid        <= 1'b0;
            tie_err        <= 1'b0;
`ifdef DFE_SCHED_STATS_EN
            sym_count      <= 32'd0;
            tie_count      <= 16'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_valid && s_ready) begin
                        r_sample <= s_data;
                        s_ready  <= 1'b0;
                        r_state  <= ST_COMPUTE;
                    end else begin
                        s_ready  <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    slc_estimation <= w_est;
                    slc_e_valid    <= 1'b1;
                    r_state        <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    slc_e_valid <= 1'b0;
                    r_state     <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    // A missing or off-grid decision is treated as a tie and forced to +1.
                    if (slc_f_valid && w_dec.match) begin
                        m_symbol   <= w_dec.sym;
                        m_level    <= slc_feedback;
                        r_dec_mult <= w_dec.mult;
                    end else begin
                        m_symbol   <= SYM_P1;
                        m_level    <= LVL_P1;
                        r_dec_mult <= 3'sd1;
                        tie_err    <= 1'b1;
`ifdef DFE_SCHED_STATS_EN
                        if (tie_count != 16'hFFFF) begin
                            tie_count <= tie_count + 16'd1;
                        end
`endif
                    end
                    m_valid <= 1'b1;
                    r_state <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        r_hist  <= {r_hist[(NUM_TAPS-1)*3-1:0], r_dec_mult};
                        s_ready <= 1'b1;
                        r_state <= ST_IDLE;
`ifdef DFE_SCHED_STATS_EN
                        sym_count <= sym_count + 32'd1;
`endif
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    s_ready     <= 1'b0;
                    slc_e_valid <= 1'b0;
                    m_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dfe_slicer_scheduler.sv
// Scoreboard bench: randomized samples against an arithmetic DFE model and a nearest-level slicer model.
module tb_dfe_slicer_scheduler;

    localparam int SR = 8;
    localparam int DW = 16;
    localparam int NT = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] s_data = '0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [NT*SR-1:0]     tap_coef = '0;
    logic signed [DW-1:0] slc_estimation;
    logic                 slc_e_valid;
    logic signed [DW-1:0] slc_feedback = '0;
    logic                 slc_f_valid = 1'b0;
    logic [1:0]           m_symbol;
    logic signed [DW-1:0] m_level;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic                 tie_err;

    dfe_slicer_scheduler dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .tap_coef(tap_coef), .slc_estimation(slc_estimation), .slc_e_valid(slc_e_valid),
        .slc_feedback(slc_feedback), .slc_f_valid(slc_f_valid), .m_symbol(m_symbol),
        .m_level(m_level), .m_valid(m_valid), .m_ready(m_ready), .tie_err(tie_err)
    );

    always #5 clk = ~clk;

    typedef struct { int sym; int level; bit tie; } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t out_q[$];
    int   est_q[$];
    int   mode_q[$];
    int   mh[NT];
    bit   tie_seen = 1'b0;
    int   bp_mode = 0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp16(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Nearest PAM4 level for S=56; exact decision boundaries are ties.
    function automatic int ref_level(int e, output bit tie);
        tie = 1'b0;
        if (e == 0 || e == 56 || e == -56) begin
            tie = 1'b1;
            return 28;
        end
        if (e > 56) return 84;
        if (e > 0) return 28;
        if (e > -56) return -28;
        return -84;
    endfunction

    // Slicer model: answers in the cycle after the issue strobe.
    always @(negedge clk) begin
        int m;
        bit t;
        if (!rst && slc_e_valid) begin
            if (est_q.size() == 0) begin
                check("est_unexpected", 1, 0);
            end else begin
                check("estimation", int'(slc_estimation), est_q.pop_front());
            end
            m = (mode_q.size() != 0) ? mode_q.pop_front() : 0;
            if (m == 1) begin
                slc_f_valid  = 1'b0;
                slc_feedback = 16'sd84;
            end else if (m == 2) begin
                slc_f_valid  = 1'b1;
                slc_feedback = 16'sd27;
            end else begin
                slc_feedback = DW'(ref_level(int'(slc_estimation), t));
                slc_f_valid  = !t;
            end
        end
    end

    // Output monitor: compares the head of the scoreboard while m_valid is up.
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            check("s_ready_excl", int'(s_ready), 0);
            if (out_q.size() == 0) begin
                check("m_valid_unexpected", 1, 0);
            end else begin
                check("m_symbol", int'(m_symbol), out_q[0].sym);
                check("m_level", int'(m_level), out_q[0].level);
                check("tie_err", int'(tie_err), int'(out_q[0].tie));
                if (m_ready) void'(out_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) m_ready = 1'b1;
            else if (bp_mode == 1) m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(int data, int c0, int c1, int mode);
        int n = 0;
        int isi, est, lvl, sym;
        bit t;
        @(negedge clk);
        while (!s_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", 0, 1);
            return;
        end
        isi = c0 * mh[0] + c1 * mh[1];
        est = clamp16(data - clamp16(isi));
        lvl = ref_level(est, t);
        if (mode != 0) begin
            t   = 1'b1;
            lvl = 28;
        end
        sym = (lvl + 84) / 56;
        tie_seen = tie_seen | t;
        est_q.push_back(est);
        mode_q.push_back(mode);
        out_q.push_back('{sym: sym, level: lvl, tie: tie_seen});
        mh[1] = mh[0];
        mh[0] = 2 * sym - 3;
        tap_coef = {SR'(c1), SR'(c0)};
        s_data   = DW'(data);
        s_valid  = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((out_q.size() != 0 || !s_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(out_q.size()), 0);
    endtask

    task automatic clear_model();
        est_q.delete();
        mode_q.delete();
        out_q.delete();
        mh[0] = 0;
        mh[1] = 0;
        tie_seen = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, mode, r;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_e_valid", int'(slc_e_valid), 0);
        check("rst_estimation", int'(slc_estimation), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_symbol", int'(m_symbol), 0);
        check("rst_m_level", int'(m_level), 0);
        check("rst_tie_err", int'(tie_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("s_ready_after_rst", int'(s_ready), 1);

        send(30, 10, 0, 0);
        send(40, 10, 0, 0);
        send(-100, 10, 0, 0);
        send(20, 10, 0, 1);
        send(32767, -128, 0, 0);
        send(-32768, 127, 0, 2);
        drain();

        // Backpressure: hold m_ready low for three cycles with m_valid up.
        bp_mode = 2;
        m_ready = 1'b0;
        send(-200, -50, 30, 0);
        r = 0;
        while (!m_valid && r < 20) begin
            @(negedge clk);
            r++;
        end
        repeat (3) begin
            @(negedge clk);
            check("bp_m_valid_held", int'(m_valid), 1);
            check("bp_s_ready", int'(s_ready), 0);
        end
        m_ready = 1'b1;
        bp_mode = 0;
        send(100, -50, 30, 0);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            if ($urandom_range(0, 7) == 0) d = $signed(16'($urandom));
            else d = $urandom_range(0, 600) - 300;
            send(d, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, mode);
        end
        drain();
        bp_mode = 0;

        // Abort a sample in DECIDE with reset.
        send(30, 10, 0, 0);
        send(50, 10, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        repeat (6) begin
            @(negedge clk);
            check("abort_no_m_valid", int'(m_valid), 0);
        end
        check("abort_tie_err", int'(tie_err), 0);
        send(30, 10, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
